qenc_array: RTL and testbench

- Parametrised N-channel quadrature encoder interface. Successor to the fixed 2-channel encoder input of the motor-control top.
- Per channel: pin synchronisation, glitch filtering, x1/x2/x4 decoding, direction invert, wrapping signed position counter, periodic saturating velocity sample and a sticky illegal-transition flag.
- Feeds the PID loops and the UART telemetry path.

---
 rtl/qenc_pkg.sv | 62 ++++++
 rtl/qenc_array_channel.sv | 140 ++++++++++++++
 rtl/qenc_array.sv | 75 +++++++
 tb/tb_qenc_array.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder array: decode modes,
// the forward AB sequence and the per-transition step decoder.
package qenc_pkg;

  localparam logic [1:0] QENC_X1 = 2'b00;
  localparam logic [1:0] QENC_X2 = 2'b01;
  localparam logic [1:0] QENC_X4 = 2'b10;

  // Forward rotation (A leads B), AB packed as {A, B}
  localparam logic [1:0] QENC_SEQ0 = 2'b00;
  localparam logic [1:0] QENC_SEQ1 = 2'b10;
  localparam logic [1:0] QENC_SEQ2 = 2'b11;
  localparam logic [1:0] QENC_SEQ3 = 2'b01;

  typedef struct packed {
    logic valid;    // transition produces a count
    logic dir;      // 1 = forward (+1), 0 = reverse (-1)
    logic illegal;  // both pins changed together
  } qenc_step_t;

  function automatic logic [1:0] qenc_fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      QENC_SEQ0: nxt = QENC_SEQ1;
      QENC_SEQ1: nxt = QENC_SEQ2;
      QENC_SEQ2: nxt = QENC_SEQ3;
      default:   nxt = QENC_SEQ0;
    endcase
    return nxt;
  endfunction

  function automatic qenc_step_t qenc_decode(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab,
                                             input logic [1:0] mode);
    qenc_step_t s;
    logic       a_chg;
    logic       b_chg;
    s     = '0;
    a_chg = prev_ab[1] ^ cur_ab[1];
    b_chg = prev_ab[0] ^ cur_ab[0];
    if (a_chg && b_chg) begin
      s.illegal = 1'b1;
    end else if (a_chg || b_chg) begin
      case (mode)
        QENC_X1: begin
          s.valid = a_chg & cur_ab[1];
          s.dir   = ~cur_ab[0];
        end
        QENC_X2: begin
          s.valid = a_chg;
          s.dir   = cur_ab[1] ^ cur_ab[0];
        end
        default: begin
          s.valid = 1'b1;
          s.dir   = (cur_ab == qenc_fwd_next(prev_ab));
        end
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/qenc_array_channel.sv
// One encoder channel: pin synchronisers, glitch filter, priming, decode,
// wrapping position counter, saturating velocity accumulator and sticky error.
module qenc_channel
  import qenc_pkg::*;
#(
  parameter int POS_W       = 32,
  parameter int VEL_W       = 16,
  parameter int FILT_LEN    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enc_a_i,
  input  logic             enc_b_i,
  input  logic [1:0]       mode_i,
  input  logic             invert_i,
  input  logic             clear_pos_i,
  input  logic             err_clr_i,
  input  logic             sample_i,
  output logic [POS_W-1:0] position_o,
  output logic [VEL_W-1:0] velocity_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam int PRM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-2){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [1:0]             sync_ab;
  logic [1:0]             filt_q;
  logic [CNT_W-1:0]       fcnt_q [2];
  logic [PRM_W-1:0]       prime_cnt_q;
  logic                   primed_q;
  logic [1:0]             prev_ab_q;
  qenc_step_t             dec;
  logic                   step_up;
  logic                   step_dn;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [VEL_W-1:0]       acc_q, acc_d, acc_step;
  logic [VEL_W-1:0]       vel_q, vel_d;
  logic                   err_q, err_d;

  assign sync_ab = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // Shift each asynchronous pin through its synchroniser chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= SYNC_STAGES'({sync_a_q, enc_a_i});
      sync_b_q <= SYNC_STAGES'({sync_b_q, enc_b_i});
    end
  end

  // Priming waits until the synchronisers hold real pin values, so a
  // resting non-00 state is adopted as the baseline instead of a step
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else if (!primed_q) begin
      if (prime_cnt_q == PRM_W'(SYNC_STAGES)) primed_q <= 1'b1;
      else prime_cnt_q <= prime_cnt_q + PRM_W'(1);
    end
  end

  // Glitch filter: seeded directly while priming, then a bit only follows
  // the synchroniser after FILT_LEN consecutive differing cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= '0;
      for (int k = 0; k < 2; k++) fcnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!primed_q) begin
          filt_q[k] <= sync_ab[k];
          fcnt_q[k] <= '0;
        end else if (sync_ab[k] == filt_q[k]) begin
          fcnt_q[k] <= '0;
        end else if (fcnt_q[k] == CNT_W'(FILT_LEN - 1)) begin
          filt_q[k] <= sync_ab[k];
          fcnt_q[k] <= '0;
        end else begin
          fcnt_q[k] <= fcnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Decode the filtered transition and apply the direction invert
  always_comb begin
    dec     = qenc_decode(prev_ab_q, filt_q, mode_i);
    step_up = primed_q & dec.valid & (dec.dir ^ invert_i);
    step_dn = primed_q & dec.valid & ~(dec.dir ^ invert_i);
  end

  // Next-state for position, velocity accumulator and error flag
  always_comb begin
    pos_d = pos_q;
    if (clear_pos_i)  pos_d = '0;
    else if (step_up) pos_d = pos_q + POS_W'(1);
    else if (step_dn) pos_d = pos_q - POS_W'(1);

    acc_step = acc_q;
    if (step_up && (acc_q != VEL_MAX))      acc_step = acc_q + VEL_W'(1);
    else if (step_dn && (acc_q != VEL_MIN)) acc_step = acc_q - VEL_W'(1);
    acc_d = sample_i ? '0 : acc_step;
    vel_d = sample_i ? acc_step : vel_q;

    err_d = err_q;
    if (primed_q && dec.illegal) err_d = 1'b1;
    else if (err_clr_i)          err_d = 1'b0;
  end

  // Channel state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_ab_q <= '0;
      pos_q     <= '0;
      acc_q     <= '0;
      vel_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      prev_ab_q <= primed_q ? filt_q : sync_ab;
      pos_q     <= pos_d;
      acc_q     <= acc_d;
      vel_q     <= vel_d;
      err_q     <= err_d;
    end
  end

  assign position_o = pos_q;
  assign velocity_o = vel_q;
  assign err_o      = err_q;

endmodule

// File: rtl/qenc_array.sv
// N-channel quadrature encoder interface: shared velocity sample divider
// plus one qenc_channel per encoder.
module qenc_array
  import qenc_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int POS_W       = 32,
  parameter int VEL_W       = 16,
  parameter int FILT_LEN    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV  = 100000
) (
  input  logic                  clk,
  input  logic                  CPU_RESET,
  input  logic [N_CH-1:0]       ENC_A,
  input  logic [N_CH-1:0]       ENC_B,
  input  logic [1:0]            mode,
  input  logic [N_CH-1:0]       invert,
  input  logic [N_CH-1:0]       clear_pos,
  input  logic [N_CH-1:0]       err_clr,
  output logic [N_CH*POS_W-1:0] position,
  output logic [N_CH*VEL_W-1:0] velocity,
  output logic                  vel_valid,
  output logic [N_CH-1:0]       err
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sample_tc;
  logic             vel_valid_q;

  assign sample_tc = (div_q == DIV_W'(SAMPLE_DIV - 1));

  // Sample divider wraps on its terminal count
  always_comb begin
    div_d = sample_tc ? '0 : div_q + DIV_W'(1);
  end

  // Divider state and the vel_valid pulse one cycle after the sample
  always_ff @(posedge clk or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      div_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      vel_valid_q <= sample_tc;
    end
  end

  assign vel_valid = vel_valid_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    qenc_channel #(
      .POS_W      (POS_W),
      .VEL_W      (VEL_W),
      .FILT_LEN   (FILT_LEN),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (CPU_RESET),
      .enc_a_i    (ENC_A[i]),
      .enc_b_i    (ENC_B[i]),
      .mode_i     (mode),
      .invert_i   (invert[i]),
      .clear_pos_i(clear_pos[i]),
      .err_clr_i  (err_clr[i]),
      .sample_i   (sample_tc),
      .position_o (position[i*POS_W +: POS_W]),
      .velocity_o (velocity[i*VEL_W +: VEL_W]),
      .err_o      (err[i])
    );
  end

endmodule

// File: tb/tb_qenc_array.sv
// Bench for qenc_array: a 32-bit/16-bit instance and an 8-bit/8-bit instance
// share the same pin stimulus; positions are tracked by a direction-based
// model of the quadrature sequence.
module tb_qenc_array;

  localparam int N_CH  = 2;
  localparam int LAT   = 2 + 4 + 1;
  localparam int DIV_A = 1000;
  localparam int DIV_B = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  enc_a, enc_b, invert, clear_pos, err_clr, mode;
  logic [63:0] pos_a;
  logic [31:0] vel_a;
  logic        vv_a;
  logic [1:0]  err_a;
  logic [15:0] pos_b;
  logic [15:0] vel_b;
  logic        vv_b;
  logic [1:0]  err_b;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit   [31:0] pos_m [N_CH];
  logic [1:0]  seq [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qenc_array #(.N_CH(2), .POS_W(32), .VEL_W(16), .FILT_LEN(4), .SYNC_STAGES(2),
               .SAMPLE_DIV(DIV_A)) dut_a (
    .clk(clk), .CPU_RESET(rst), .ENC_A(enc_a), .ENC_B(enc_b), .mode(mode),
    .invert(invert), .clear_pos(clear_pos), .err_clr(err_clr),
    .position(pos_a), .velocity(vel_a), .vel_valid(vv_a), .err(err_a));

  qenc_array #(.N_CH(2), .POS_W(8), .VEL_W(8), .FILT_LEN(4), .SYNC_STAGES(2),
               .SAMPLE_DIV(DIV_B)) dut_b (
    .clk(clk), .CPU_RESET(rst), .ENC_A(enc_a), .ENC_B(enc_b), .mode(mode),
    .invert(invert), .clear_pos(clear_pos), .err_clr(err_clr),
    .position(pos_b), .velocity(vel_b), .vel_valid(vv_b), .err(err_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pos();
    for (int ch = 0; ch < N_CH; ch++) begin
      check($sformatf("pos_a ch%0d", ch), pos_a[ch*32 +: 32], pos_m[ch]);
      check($sformatf("pos_b ch%0d", ch), pos_b[ch*8 +: 8], pos_m[ch][7:0]);
    end
  endtask

  task automatic check_err(input logic [1:0] exp);
    check("err_a", err_a, exp);
    check("err_b", err_b, exp);
  endtask

  // Count contributed by one quadrature move, from the rotation direction
  function automatic int model_delta(input logic [1:0] oab, input logic [1:0] nab,
                                     input bit fwd, input logic [1:0] md, input logic inv);
    int d;
    if (md == 2'b00)      d = (!oab[1] && nab[1]) ? 1 : 0;
    else if (md == 2'b01) d = (oab[1] != nab[1]) ? 1 : 0;
    else                  d = 1;
    if (!fwd) d = -d;
    if (inv)  d = -d;
    return d;
  endfunction

  task automatic move(input int ch, input bit fwd, input int hold);
    logic [1:0] oab, nab;
    int idx;
    oab = {enc_a[ch], enc_b[ch]};
    idx = 0;
    for (int k = 0; k < 4; k++) if (seq[k] == oab) idx = k;
    nab = fwd ? seq[(idx + 1) % 4] : seq[(idx + 3) % 4];
    pos_m[ch] = pos_m[ch] + 32'(model_delta(oab, nab, fwd, mode, invert[ch]));
    enc_a[ch] = nab[1];
    enc_b[ch] = nab[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic clear_ch(input int ch);
    clear_pos[ch] = 1'b1;
    @(negedge clk);
    clear_pos[ch] = 1'b0;
    pos_m[ch] = '0;
    @(negedge clk);
  endtask

  task automatic wait_vv(input bit use_b, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((use_b ? vv_b : vv_a) !== 1'b1) && (n < 2500));
    check(use_b ? "vv_b_wait" : "vv_a_wait", use_b ? vv_b : vv_a, 1'b1);
    at = cyc;
  endtask

  initial begin
    int t0, t1, t2, lat;
    logic [31:0] p;
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    enc_a = 2'b11; enc_b = 2'b11; mode = 2'b10; invert = '0;
    clear_pos = '0; err_clr = '0; rst = 1'b1;
    for (int ch = 0; ch < N_CH; ch++) pos_m[ch] = '0;

    // Reset values and priming with pins resting at 11
    repeat (3) @(negedge clk);
    check("rst pos_a", pos_a, 64'd0);
    check("rst vel_a", vel_a, 32'd0);
    check("rst vv_a", vv_a, 1'b0);
    check_err(2'b00);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_pos();
    check_err(2'b00);

    // x4 forward and reverse on ch0
    repeat (32) move(0, 1'b1, 10);
    check("x4 fwd 32", pos_a[31:0], 32'd32);
    check_pos();
    repeat (32) move(0, 1'b0, 10);
    check_pos();

    // Same four forward cycles in each mode
    for (int m = 0; m < 3; m++) begin
      mode = 2'(m);
      clear_ch(0);
      repeat (16) move(0, 1'b1, 10);
      check($sformatf("mode %0d count", m), pos_a[31:0], 32'd4 << m);
      check_pos();
    end
    mode = 2'b10;
    invert[0] = 1'b1;
    clear_ch(0);
    repeat (16) move(0, 1'b1, 10);
    check("invert x4", pos_a[31:0], 32'hFFFF_FFF0);
    check_pos();
    invert[0] = 1'b0;

    // Pin-to-position latency
    p = pos_a[31:0];
    lat = 0;
    move(0, 1'b1, 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pos_a[31:0] !== p) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, LAT);
    repeat (10) @(negedge clk);
    check_pos();

    // 3-cycle glitch on A is filtered out
    enc_a[0] = ~enc_a[0];
    repeat (3) @(negedge clk);
    enc_a[0] = ~enc_a[0];
    repeat (20) @(negedge clk);
    check_pos();
    check_err(2'b00);

    // Illegal transition, clear, and clear coincident with a new illegal
    enc_a[0] = ~enc_a[0]; enc_b[0] = ~enc_b[0];
    repeat (12) @(negedge clk);
    check_err(2'b01);
    check_pos();
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    check_err(2'b00);
    enc_a[0] = ~enc_a[0]; enc_b[0] = ~enc_b[0];
    repeat (LAT - 1) @(negedge clk);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    check_err(2'b01);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    check_err(2'b00);

    // Randomised moves with random mode and invert
    for (int i = 0; i < 40; i++) begin
      mode   = 2'($urandom_range(0, 3));
      invert = 2'($urandom_range(0, 3));
      move($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(8, 12));
      check_pos();
    end
    mode = 2'b10; invert = '0;
    check_err(2'b00);

    // Velocity: 25 steps in one window, then an idle window
    wait_vv(1'b0, t0);
    repeat (25) move(0, 1'b1, 10);
    wait_vv(1'b0, t1);
    check("vel period", t1 - t0, DIV_A);
    check("vel ch0 25", vel_a[15:0], 16'd25);
    check("vel ch1 idle", vel_a[31:16], 16'd0);
    @(negedge clk);
    check("vv one cycle", vv_a, 1'b0);
    wait_vv(1'b0, t2);
    check("vel idle", vel_a[15:0], 16'd0);

    // Step landing on the terminal count belongs to that sample
    repeat (DIV_A - LAT) @(negedge clk);
    move(0, 1'b1, 0);
    wait_vv(1'b0, t0);
    check("vel tc step", vel_a[15:0], 16'd1);
    wait_vv(1'b0, t1);
    check("vel after tc", vel_a[15:0], 16'd0);

    // 8-bit velocity saturates
    wait_vv(1'b1, t0);
    repeat (200) move(0, 1'b1, 6);
    wait_vv(1'b1, t1);
    check("vel8 sat", vel_b[7:0], 8'd127);
    check_pos();

    // Wrap below zero
    clear_ch(0);
    move(0, 1'b0, 10);
    check("wrap pos_b", pos_b[7:0], 8'hFF);
    check_pos();

    // clear_pos beats a coincident step
    move(0, 1'b1, 0);
    repeat (LAT - 1) @(negedge clk);
    clear_pos[0] = 1'b1;
    @(negedge clk);
    clear_pos[0] = 1'b0;
    pos_m[0] = '0;
    repeat (5) @(negedge clk);
    check_pos();

    // Asynchronous reset mid-sequence, no phantom step after release
    while ({enc_a[0], enc_b[0]} != 2'b10) move(0, 1'b1, 10);
    move(0, 1'b1, 3);
    #2 rst = 1'b1;
    #1;
    check("async pos_a", pos_a, 64'd0);
    check("async pos_b", pos_b, 16'd0);
    check("async vel_b", vel_b, 16'd0);
    check("async vv", {vv_a, vv_b}, 2'b00);
    check_err(2'b00);
    @(negedge clk);
    for (int ch = 0; ch < N_CH; ch++) pos_m[ch] = '0;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_pos();
    check_err(2'b00);
    move(0, 1'b1, 10);
    check_pos();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
